// File: rtl/cpu_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// cpu_issue_ctrl_if
// Handshake and status bundle between the instruction loader/core side and the
// issue controller.
//   in_valid/in_ready/in_word : loader push handshake (16-bit instruction word)
//   iss_word/iss_valid        : registered word presented to the core
//   resume/flush              : control pulses from the environment
//   halted/level/count        : controller status
// Modports:
//   master : environment side (loader, core, control source)
//   slave  : issue controller side
// -----------------------------------------------------------------------------
interface cpu_issue_ctrl_if #(
  parameter int LOG_DEPTH = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [15:0]          in_word;
  logic [15:0]          iss_word;
  logic                 iss_valid;
  logic                 resume;
  logic                 flush;
  logic                 halted;
  logic [LOG_DEPTH:0]   level;
  logic [15:0]          count;

  modport master (
    output in_valid, in_word, resume, flush,
    input  in_ready, iss_word, iss_valid, halted, level, count
  );

  modport slave (
    input  in_valid, in_word, resume, flush,
    output in_ready, iss_word, iss_valid, halted, level, count
  );
endinterface

// File: rtl/cpu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_issue_ctrl
// Instruction issue controller for the 8-bit CPU core. Buffers 16-bit words
// {op, r1, r2, r3} from a loader in a DEPTH-entry FIFO and issues at most one
// word per cycle. Cycles that issue nothing present a NOP (16'h4000). Opcode
// 4'b0111 (HALT) is consumed without issuing and parks the controller until
// resume. flush empties the FIFO and returns to RUN.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active-high
//   bus        cpu_issue_ctrl_if.slave (push handshake, issue outputs,
//              resume/flush controls, halted/level/count status)
//   step_mode  (ISSUE_STEP_EN only) 1 = one pop per step pulse
//   step       (ISSUE_STEP_EN only) step pulse; ignored when FIFO is empty
//
// Build option: define ISSUE_STEP_EN to add single-step issue control.
// -----------------------------------------------------------------------------
module cpu_issue_ctrl #(
  parameter int DEPTH     = 4,
  parameter int LOG_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_issue_ctrl_if.slave      bus
`ifdef ISSUE_STEP_EN
  ,
  input  logic                 step_mode,
  input  logic                 step
`endif
);

  localparam logic [15:0] NOP_WORD = 16'h4000;
  localparam logic [3:0]  OP_HALT  = 4'b0111;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t                state_q, state_d;

  logic [15:0]           mem [DEPTH];
  logic [LOG_DEPTH-1:0]  rd_ptr, wr_ptr;
  logic [LOG_DEPTH:0]    level_q;
  logic [15:0]           iss_word_q;
  logic                  iss_valid_q;
  logic [15:0]           count_q;

  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  step_ok;
  logic [15:0]           head;
  logic                  head_is_halt;

  assign full         = (level_q == (LOG_DEPTH+1)'(DEPTH));
  assign head         = mem[rd_ptr];
  assign head_is_halt = (head[15:12] == OP_HALT);

`ifdef ISSUE_STEP_EN
  // A step only matters when it coincides with a pop opportunity; no credit
  // is kept, so a step against an empty FIFO is simply lost.
  assign step_ok = !step_mode || step;
`else
  assign step_ok = 1'b1;
`endif

  // Full blocks pushes even if a pop frees a slot this cycle: no pass-through.
  assign bus.in_ready = !full && !bus.flush;
  assign push         = bus.in_valid && bus.in_ready;
  // Pop reads the pre-push head, so a word pushed into an empty FIFO issues
  // one edge later rather than bypassing.
  assign pop          = (state_q == RUN) && (level_q != '0) && step_ok && !bus.flush;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours; blocking here would create order-
  // dependent simulation and sim/synthesis mismatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. resume is only looked at in HALT, so a resume arriving
  // in the same cycle a HALT word is popped is ignored.
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets its default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (pop && head_is_halt) state_d = HALT;
        HALT:    if (bus.resume)          state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  assign bus.halted = (state_q == HALT);

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; occupancy and pointers alone decide
  // which entries are meaningful, and leaving it unreset lets it map to plain
  // RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_word;
  end

  // Pointers and occupancy. Pointers are LOG_DEPTH bits and wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
    end else if (bus.flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Issue register and issued-instruction counter. Anything other than a
  // non-HALT pop presents a NOP so the datapath holds its state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_word_q  <= NOP_WORD;
      iss_valid_q <= 1'b0;
      count_q     <= '0;
    end else if (pop && !head_is_halt) begin
      iss_word_q  <= head;
      iss_valid_q <= 1'b1;
      count_q     <= count_q + 1'b1;
    end else begin
      iss_word_q  <= NOP_WORD;
      iss_valid_q <= 1'b0;
    end
  end

  assign bus.iss_word  = iss_word_q;
  assign bus.iss_valid = iss_valid_q;
  assign bus.level     = level_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_cpu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_issue_ctrl
// Self-checking bench for cpu_issue_ctrl. A queue-based reference model tracks
// the FIFO contents, halt status, expected issue word and issued count; every
// cycle the DUT outputs are compared against it. Directed steps follow the
// documented scenarios, then a randomized phase exercises mixed traffic.
// -----------------------------------------------------------------------------
module tb_cpu_issue_ctrl;

  localparam int          DEPTH     = 4;
  localparam int          LOG_DEPTH = 2;
  localparam logic [15:0] NOP       = 16'h4000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic step_mode = 1'b0;
  logic step      = 1'b0;

  always #5 clk = ~clk;

  cpu_issue_ctrl_if #(.LOG_DEPTH(LOG_DEPTH)) bus ();

  cpu_issue_ctrl #(.DEPTH(DEPTH), .LOG_DEPTH(LOG_DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave)
`ifdef ISSUE_STEP_EN
    ,
    .step_mode (step_mode),
    .step      (step)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [15:0] q[$];
  logic        m_halted = 1'b0;
  logic [15:0] m_word   = NOP;
  logic        m_valid  = 1'b0;
  logic [15:0] m_count  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_halted = 1'b0;
    m_word   = NOP;
    m_valid  = 1'b0;
    m_count  = '0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".iss_word"},  32'(bus.iss_word),  32'(m_word));
    check({tag, ".iss_valid"}, 32'(bus.iss_valid), 32'(m_valid));
    check({tag, ".halted"},    32'(bus.halted),    32'(m_halted));
    check({tag, ".level"},     32'(bus.level),     32'(q.size()));
    check({tag, ".count"},     32'(bus.count),     32'(m_count));
  endtask

  // One clock cycle: drive inputs, check in_ready, clock, advance model, check.
  task automatic cyc(input string tag, input logic v, input logic [15:0] w,
                     input logic res, input logic fl,
                     input logic sm, input logic st);
    logic        exp_ready;
    logic        was_halted;
    logic        step_ok;
    logic [15:0] hw;
    bus.in_valid = v;
    bus.in_word  = w;
    bus.resume   = res;
    bus.flush    = fl;
    step_mode    = sm;
    step         = st;
    #1;
    exp_ready = (q.size() != DEPTH) && !fl;
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(exp_ready));
    @(posedge clk);
`ifdef ISSUE_STEP_EN
    step_ok = !sm || st;
`else
    step_ok = 1'b1;
`endif
    m_word  = NOP;
    m_valid = 1'b0;
    if (fl) begin
      q.delete();
      m_halted = 1'b0;
    end else begin
      was_halted = m_halted;
      if (!was_halted && q.size() > 0 && step_ok) begin
        hw = q.pop_front();
        if (hw[15:12] == 4'h7) m_halted = 1'b1;
        else begin
          m_word  = hw;
          m_valid = 1'b1;
          m_count = m_count + 16'd1;
        end
      end else if (was_halted && res) begin
        m_halted = 1'b0;
      end
      if (v && exp_ready) q.push_back(w);
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input string tag, input logic [15:0] w);
    cyc(tag, 1'b1, w, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] cnt0;
    logic [15:0] rw;
    logic        rv, rr, rf;

    bus.in_valid = 1'b0;
    bus.in_word  = '0;
    bus.resume   = 1'b0;
    bus.flush    = 1'b0;

    // ---- Reset: held 2 cycles, released away from the edge
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("reset.iss_word",  32'(bus.iss_word),  32'(NOP));
    check("reset.iss_valid", 32'(bus.iss_valid), 32'(0));
    check("reset.level",     32'(bus.level),     32'(0));
    check("reset.count",     32'(bus.count),     32'(0));
    check("reset.halted",    32'(bus.halted),    32'(0));
    check("reset.in_ready",  32'(bus.in_ready),  32'(1));

    // ---- Single issue: pushed at N, issued after N+1, NOP after N+2
    push("single.push", 16'h1305);
    check("single.not_bypassed", 32'(bus.iss_valid), 32'(0));
    idle("single.issue", 1);
    check("single.word", 32'(bus.iss_word), 32'h1305);
    idle("single.after", 1);
    check("single.nop",   32'(bus.iss_word), 32'(NOP));
    check("single.count", 32'(bus.count),    32'd1);

    // ---- Fill behind a HALT, then try a fifth word
    push("fill.halt", 16'h7000);
    push("fill.w1",   16'h1101);
    push("fill.w2",   16'h1202);
    push("fill.w3",   16'h1303);
    push("fill.w4",   16'h1404);
    check("fill.halted", 32'(bus.halted), 32'd1);
    check("fill.level",  32'(bus.level),  32'd4);
    push("fill.reject", 16'h1505);
    check("fill.level_kept", 32'(bus.level), 32'd4);

    // ---- Resume: four words on four consecutive cycles
    cnt0 = bus.count;
    cyc("resume.pulse", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("resume.halted", 32'(bus.halted), 32'd0);
    idle("resume.drain", 4);
    check("resume.count_delta", 32'(bus.count - cnt0), 32'd4);
    check("resume.level",       32'(bus.level),         32'd0);

    // ---- HALT at head with resume same cycle: HALT still entered
    push("hres.halt", 16'h7abc);
    cyc("hres.pop_resume", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("hres.halted", 32'(bus.halted), 32'd1);

    // ---- Flush in HALT with 3 queued, in_valid asserted together with flush
    push("flush.q1", 16'h2111);
    push("flush.q2", 16'h2222);
    push("flush.q3", 16'h2333);
    cnt0 = bus.count;
    cyc("flush.do", 1'b1, 16'h2444, 1'b1, 1'b1, 1'b0, 1'b0);
    check("flush.level",  32'(bus.level),    32'd0);
    check("flush.halted", 32'(bus.halted),   32'd0);
    check("flush.count",  32'(bus.count),    32'(cnt0));
    check("flush.word",   32'(bus.iss_word), 32'(NOP));
    idle("flush.after", 2);

    // ---- Back-to-back throughput with push/pop overlap
    for (int i = 0; i < 6; i++) push("stream", 16'h3000 | 16'(i));
    idle("stream.drain", 4);

`ifdef ISSUE_STEP_EN
    // ---- Step mode: one pop per step pulse, no stored credit
    cyc("step.q1", 1'b1, 16'h2100, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("step.q2", 1'b1, 16'h2200, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("step.wait", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("step.no_issue", 32'(bus.iss_valid), 32'd0);
    cyc("step.s1", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("step.s1_word", 32'(bus.iss_word), 32'h2100);
    cyc("step.s2", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("step.s2_word", 32'(bus.iss_word), 32'h2200);
    cyc("step.empty", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("step.empty_valid", 32'(bus.iss_valid), 32'd0);
    cyc("step.q3", 1'b1, 16'h2300, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("step.no_credit", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("step.no_credit_valid", 32'(bus.iss_valid), 32'd0);
    cyc("step.s3", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("step.s3_word", 32'(bus.iss_word), 32'h2300);
`endif

    // ---- Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rw = 16'($urandom());
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) == 0);
      rf = ($urandom_range(0, 19) == 0);
      cyc("rand", rv, rw, rr, rf, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // ---- Reset mid-operation: state clears without waiting for an edge
    push("mrst.p1", 16'h1aaa);
    push("mrst.p2", 16'h1bbb);
    rst = 1'b1;
    #1;
    model_reset();
    check("mrst.level",    32'(bus.level),     32'd0);
    check("mrst.count",    32'(bus.count),     32'd0);
    check("mrst.iss_word", 32'(bus.iss_word),  32'(NOP));
    check("mrst.halted",   32'(bus.halted),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle("mrst.after", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
